core_rr_scheduler: RTL and testbench
====================================

// Module: core_rr_scheduler
// PURPOSE
//  Shares one iterative compute core (5-bit state FSM with load/scan_en/scan_state) between N_REQ requesters.
//  Round-robin grant, operand muxing, core_load pulse generation.
//  Job completion is detected from the core state (END1/END2); result and status return to the granted requester.
//  Sits between client blocks and the core inside the top level; the core is not modified.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  DW       16    operand/result width
//  TIMEOUT  1023  max WAIT cycles before abort (used only with CORE_WDOG_EN)
// PORTS
//  clk             in   1         single clock, rising edge
//  reset           in   1         synchronous, active-low
//  req             in   N_REQ     per-requester job request, level; held until done
//  opa_flat        in   N_REQ*DW  operand A, requester i at [i*DW +: DW]
//  opb_flat        in   N_REQ*DW  operand B, same packing
//  gnt             out  N_REQ     one-hot grant, held for the whole job
//  done            out  N_REQ     one-cycle completion pulse to the granted requester
//  result          out  DW        core result, valid while any done bit is high
//  err             out  1         valid with done: 1 = END2 exit or abort
//  core_load       out  1         one-cycle load pulse to core
//  core_opa/opb    out  DW        registered operands to core, stable from LOAD until DONE
//  core_state      in   5         core state vector
//  core_result     in   DW        core result bus
//  core_scan_en    out  1         forced-state enable to core (abort only)
//  core_scan_state out  5         forced state, always IDLE (5'b00000)
//  busy            out  1         high in every state except S_IDLE
// BEHAVIOUR
//  - reset==0 at a clk edge: state=S_IDLE, ptr=0, all outputs 0, operand regs 0, wdog cnt 0. Applies mid-job; the core shares the reset.
//  - S_IDLE: if |req, pick first set bit at or after ptr (wrap N_REQ-1 -> 0) -> register gnt, latch that requester's opa/opb -> S_LOAD.
//    No req: stay.
//  - S_LOAD: core_load=1 for exactly one cycle -> S_WAIT. The core enters INIT1 on the following edge.
//  - S_WAIT: if core_state==END1 (5'b11101) -> S_DONE with err=0.
//    If core_state==END2 (5'b11110) -> S_DONE with err=1. Any other state: stay.
//  - S_DONE: result<=core_result, done[g]=1, err valid, one cycle.
//    gnt cleared, ptr<=(g+1) mod N_REQ, -> S_IDLE.
//  - Latency: req sampled at edge k -> gnt high after k; core_load high in cycle k+1.
//    done appears one cycle after END1/END2 is sampled.
//  - Minimum back-to-back spacing: one S_IDLE cycle between jobs.
//  - req dropped mid-job: ignored; the job completes and done still pulses.
//    req already low in S_IDLE is never granted.
//  - Simultaneous requests: strict round-robin from ptr; no requester is granted twice while another is pending.
//  - done and a new grant never occur in the same cycle.
//  - The core_state value IDLE seen during S_LOAD/S_WAIT does not count as completion.
// CONFIGURATION
//  CORE_WDOG_EN defined:
//   - 10-bit-or-wider counter clears on S_LOAD and counts in S_WAIT.
//   - When cnt==TIMEOUT -> S_ABORT: core_scan_en=1 and core_scan_state=IDLE for one cycle -> S_DONE with err=1 and result=0.
//  CORE_WDOG_EN undefined:
//   - No counter and no S_ABORT; S_WAIT waits indefinitely.
//   - core_scan_en tied 0, core_scan_state tied 0.
// STRUCTURE
//  - core_pkg (shared with the core and its bench): core state encodings IDLE/END1/END2, state width 5, scheduler state typedef {S_IDLE,S_LOAD,S_WAIT,S_DONE,S_ABORT}.
//  - Sub-module rr_pick: combinational, inputs req+ptr, outputs one-hot gnt_next and index. Reusable by other arbiters.
// TESTING
//  Use a behavioural core model that walks IDLE->INIT1..->END1/END2->IDLE with a programmable job length.
//  1 Single request: req=4'b0010, opa=12, opb=18, core ends END1 after 20 cycles, core_result=6
//    -> gnt=0010, one core_load, done=0010, result=6, err=0.
//  2 All request: req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0; each done precedes the next gnt.
//  3 END2 exit: core model exits via END2 -> done pulse with err=1; ptr advances normally.
//  4 reset=0 asserted in S_WAIT -> next edge all outputs 0, busy=0, ptr=0; after release req=0001 -> new job starts normally.
//  5 With CORE_WDOG_EN, TIMEOUT=15, core stuck in LOOP3
//    -> on cycle 16 of WAIT, core_scan_en=1 and scan_state=0 for one cycle, then done with err=1 and result=0.
//    Without the macro the bench sees no done within 100 cycles and core_scan_en stays 0.
//  6 Requester 1 drops req mid-job -> done[1] still pulses; with req=1000 pending, next gnt=1000.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core state encodings and scheduler state type shared by the core, the scheduler and benches
package core_pkg;

    localparam int CORE_STATE_W = 5;

    localparam logic [CORE_STATE_W-1:0] CORE_IDLE = 5'b00000;
    localparam logic [CORE_STATE_W-1:0] CORE_END1 = 5'b11101;
    localparam logic [CORE_STATE_W-1:0] CORE_END2 = 5'b11110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_ABORT
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_next,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Walk the search order backwards so the last hit is the one closest to ptr.
    always_comb begin
        gnt_next = '0;
        idx      = '0;
        pos      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                gnt_next      = '0;
                gnt_next[pos] = 1'b1;
                idx           = pos;
            end
        end
    end

endmodule

// File: rtl/core_rr_scheduler.sv
// rtl/core_rr_scheduler.sv - round-robin sharing of one iterative core between N_REQ requesters
// Optional CORE_WDOG_EN: watchdog in S_WAIT that force-idles a stuck core and reports err.
module core_rr_scheduler
    import core_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DW-1:0]     opa_flat,
    input  logic [N_REQ*DW-1:0]     opb_flat,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DW-1:0]           result,
    output logic                    err,
    output logic                    core_load,
    output logic [DW-1:0]           core_opa,
    output logic [DW-1:0]           core_opb,
    input  logic [CORE_STATE_W-1:0] core_state,
    input  logic [DW-1:0]           core_result,
    output logic                    core_scan_en,
    output logic [CORE_STATE_W-1:0] core_scan_state,
    output logic                    busy
);

    localparam int IW = $clog2(N_REQ);

    sched_state_t   state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]  opa_q, opa_d;
    logic [DW-1:0]  opb_q, opb_d;
    logic [DW-1:0]  result_q, result_d;
    logic           err_q, err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;

`ifdef CORE_WDOG_EN
    localparam int WDOG_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    logic [WDOG_W-1:0] cnt_q, cnt_d;
`endif

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req      (req),
        .ptr      (ptr_q),
        .gnt_next (pick_gnt),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef CORE_WDOG_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    opa_d   = opa_flat[int'(pick_idx)*DW +: DW];
                    opb_d   = opb_flat[int'(pick_idx)*DW +: DW];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
`ifdef CORE_WDOG_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A core still showing IDLE here is just not started yet; only END1/END2 finish.
                if (core_state == CORE_END1) begin
                    result_d = core_result;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (core_state == CORE_END2) begin
                    result_d = core_result;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end
`ifdef CORE_WDOG_EN
                else if (cnt_q == WDOG_W'(TIMEOUT)) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
`ifdef CORE_WDOG_EN
            S_ABORT: begin
                result_d = '0;
                err_d    = 1'b1;
                state_d  = S_DONE;
            end
`endif
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

`ifdef CORE_WDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign core_scan_en    = (state_q == S_ABORT);
    assign core_scan_state = CORE_IDLE;
`else
    assign core_scan_en    = 1'b0;
    assign core_scan_state = '0;
`endif

    assign gnt       = gnt_q;
    assign done      = (state_q == S_DONE) ? gnt_q : '0;
    assign err       = (state_q == S_DONE) & err_q;
    assign result    = result_q;
    assign core_load = (state_q == S_LOAD);
    assign core_opa  = opa_q;
    assign core_opb  = opb_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_rr_scheduler.sv
// tb/tb_core_rr_scheduler.sv - randomized self-checking bench for core_rr_scheduler with a behavioural core
module tb_core_rr_scheduler;
    import core_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;
    localparam logic [CORE_STATE_W-1:0] LOOP3 = 5'b00100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic [N_REQ-1:0]        req;
    wire  [N_REQ*DW-1:0]     opa_flat;
    wire  [N_REQ*DW-1:0]     opb_flat;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DW-1:0]           result;
    logic                    err;
    logic                    core_load;
    logic [DW-1:0]           core_opa;
    logic [DW-1:0]           core_opb;
    logic [CORE_STATE_W-1:0] core_state;
    logic [DW-1:0]           core_result;
    logic                    core_scan_en;
    logic [CORE_STATE_W-1:0] core_scan_state;
    logic                    busy;

    logic [DW-1:0] a_op [N_REQ];
    logic [DW-1:0] b_op [N_REQ];
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
        assign opa_flat[gi*DW +: DW] = a_op[gi];
        assign opb_flat[gi*DW +: DW] = b_op[gi];
    end

    core_rr_scheduler #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .opa_flat        (opa_flat),
        .opb_flat        (opb_flat),
        .gnt             (gnt),
        .done            (done),
        .result          (result),
        .err             (err),
        .core_load       (core_load),
        .core_opa        (core_opa),
        .core_opb        (core_opb),
        .core_state      (core_state),
        .core_result     (core_result),
        .core_scan_en    (core_scan_en),
        .core_scan_state (core_scan_state),
        .busy            (busy)
    );

    // Behavioural core: IDLE -> INIT1 -> LOOP.. -> END1/END2 -> IDLE, job_len edges after load.
    int      job_len   = 10;
    bit      job_end2  = 1'b0;
    bit      job_stuck = 1'b0;
    int      cm_cnt;
    logic [DW-1:0] cm_res;

    always @(posedge clk) begin
        if (!reset) begin
            core_state <= CORE_IDLE;
            cm_cnt     <= 0;
            cm_res     <= '0;
        end else if (core_scan_en) begin
            core_state <= core_scan_state;
        end else if (core_state == CORE_IDLE) begin
            if (core_load) begin
                core_state <= 5'b00001;
                cm_cnt     <= 1;
                cm_res     <= core_opb - core_opa;
            end
        end else if (core_state == CORE_END1 || core_state == CORE_END2) begin
            core_state <= CORE_IDLE;
        end else if (job_stuck) begin
            core_state <= LOOP3;
        end else if (cm_cnt + 1 == job_len) begin
            core_state <= job_end2 ? CORE_END2 : CORE_END1;
        end else begin
            core_state <= 5'b00010;
            cm_cnt     <= cm_cnt + 1;
        end
    end
    assign core_result = cm_res;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int rr_expect(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++)
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_gnt"},  gnt, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_ctrl"}, {core_load, busy, err, core_scan_en, core_scan_state}, 0);
        check_eq({tag, "_res"},  result, 0);
        check_eq({tag, "_ops"},  {core_opa, core_opb}, 0);
    endtask

    // One job from grant to the idle cycle after done; called at a negedge with the DUT idle.
    task automatic run_job(input int len, input bit end2, input bit drop_mid,
                           input logic [N_REQ-1:0] add_mid, input bit clear_after);
        int exp_idx;
        int n;
        int loads;
        logic [DW-1:0] exp_res;
        job_len  = len;
        job_end2 = end2;
        exp_idx  = rr_expect(req, model_ptr);
        n = 0;
        while (gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        check_eq("gnt_latency", n, 1);
        check_eq("gnt", gnt, 1 << exp_idx);
        check_eq("load_at_gnt", core_load, 1);
        check_eq("core_ops", {core_opa, core_opb}, {a_op[exp_idx], b_op[exp_idx]});
        exp_res = b_op[exp_idx] - a_op[exp_idx];
        if (drop_mid) req[exp_idx] = 1'b0;
        req = req | add_mid;
        n = 0;
        loads = 0;
        do begin
            tick();
            n++;
            loads += int'(core_load);
        end while (done == '0 && n < len + 10);
        check_eq("done_latency", n, len + 1);
        check_eq("extra_loads", loads, 0);
        check_eq("done", done, 1 << exp_idx);
        check_eq("result", result, exp_res);
        check_eq("err", err, end2);
        check_eq("gnt_held", gnt, 1 << exp_idx);
        if (clear_after) req[exp_idx] = 1'b0;
        tick();
        check_eq("post_done_idle", {gnt, done, busy}, 0);
        model_ptr = (exp_idx + 1) % N_REQ;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int scan_seen;
        int done_seen;
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = DW'(i + 1);
            b_op[i] = DW'(10 * (i + 1) + 7);
        end
        repeat (3) tick();
        check_idle_zero("reset");
        reset = 1'b1;
        tick();

        // All requesting from ptr 0: grants 0,1,2,3,0 with a done before every new grant.
        req = 4'b1111;
        for (int j = 0; j < 5; j++) run_job(3 + j, 1'b0, 1'b0, '0, 1'b0);

        // Single request from requester 1.
        req = 4'b0010;
        a_op[1] = 16'd12;
        b_op[1] = 16'd18;
        run_job(20, 1'b0, 1'b0, '0, 1'b1);

        // END2 exit reports err and still advances ptr.
        req = 4'b0100;
        run_job(7, 1'b1, 1'b0, '0, 1'b1);

        // Requester 1 drops mid-job; requester 3 arrives meanwhile and is next.
        req = 4'b0010;
        run_job(9, 1'b0, 1'b1, 4'b1000, 1'b1);
        run_job(5, 1'b0, 1'b0, '0, 1'b1);

        // Move ptr off zero, then reset mid-WAIT: ptr must return to 0.
        req = 4'b0010;
        run_job(4, 1'b0, 1'b0, '0, 1'b1);
        req = 4'b0100;
        job_len = 40;
        n = 0;
        while (gnt == '0 && n < 5) begin
            tick();
            n++;
        end
        check_eq("rstw_gnt", gnt, 4'b0100);
        repeat (6) tick();
        check_eq("rstw_busy", busy, 1);
        reset = 1'b0;
        tick();
        check_idle_zero("rstw");
        reset = 1'b1;
        req = 4'b1001;
        model_ptr = 0;
        run_job(6, 1'b0, 1'b0, '0, 1'b1);
        run_job(4, 1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic against the round-robin model.
        for (int j = 0; j < 30; j++) begin
            if (req == '0) req = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                a_op[i] = DW'($urandom);
                b_op[i] = DW'($urandom);
            end
            run_job(int'($urandom_range(2, 25)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), N_REQ'($urandom_range(0, (1 << N_REQ) - 1)), 1'b1);
        end

        // Core stuck in LOOP3.
        req = 4'b0001;
        job_stuck = 1'b1;
        n = 0;
        while (gnt == '0 && n < 5) begin
            tick();
            n++;
        end
        check_eq("stuck_gnt", gnt, 4'b0001);
`ifdef CORE_WDOG_EN
        n = 0;
        while (!core_scan_en && n < TIMEOUT + 10) begin
            tick();
            n++;
        end
        check_eq("wdog_scan_at", n, TIMEOUT + 2);
        check_eq("wdog_scan_state", core_scan_state, 0);
        check_eq("wdog_no_done_yet", done, 0);
        tick();
        check_eq("wdog_scan_one_cycle", core_scan_en, 0);
        check_eq("wdog_done", done, 4'b0001);
        check_eq("wdog_err", err, 1);
        check_eq("wdog_result", result, 0);
`else
        scan_seen = 0;
        done_seen = 0;
        repeat (100) begin
            tick();
            if (core_scan_en) scan_seen++;
            if (done != '0) done_seen++;
        end
        check_eq("nowdog_done", done_seen, 0);
        check_eq("nowdog_scan", scan_seen, 0);
        check_eq("nowdog_busy", busy, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
